// File: rtl/sram_pkg.sv
// Shared definitions for the ZBT SRAM pin protocol, used by the responder and the controller.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W   = 20;
  localparam int unsigned SRAM_DATA_W   = 18;
  localparam int unsigned SRAM_LANE_W   = 9;
  localparam int unsigned SRAM_PIPE_LAT = 2;

  typedef enum logic [1:0] {OP_NOP, OP_RD, OP_WR} sram_op_e;

  typedef struct packed {
    sram_op_e               op;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [1:0]             bw;
  } sram_cmd_t;

  // Linear burst: the low two bits wrap inside the 4-word aligned block.
  function automatic logic [SRAM_ADDR_W-1:0] burst_addr(input logic [SRAM_ADDR_W-1:0] base,
                                                        input logic [1:0] cnt);
    logic [1:0] low;
    low = base[1:0] + cnt + 2'd1;
    return {base[SRAM_ADDR_W-1:2], low};
  endfunction

endpackage

// File: rtl/zbt_sram_array.sv
// Single-clock word storage: synchronous read, per-lane write, write-first on address collision.
module zbt_sram_array
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH_BITS = 12
) (
  input  logic                   clk,
  input  logic                   rd_en,
  input  logic [DEPTH_BITS-1:0]  rd_addr,
  output logic [SRAM_DATA_W-1:0] rd_data,
  input  logic [1:0]             wr_en,
  input  logic [DEPTH_BITS-1:0]  wr_addr,
  input  logic [SRAM_DATA_W-1:0] wr_data
);

  logic [SRAM_DATA_W-1:0] mem_q [2**DEPTH_BITS];

  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < 2; l++) begin
      if (wr_en[l]) begin
        mem_q[wr_addr][l*SRAM_LANE_W +: SRAM_LANE_W] <= wr_data[l*SRAM_LANE_W +: SRAM_LANE_W];
      end
    end
    if (rd_en) begin
      for (int unsigned l = 0; l < 2; l++) begin
        if (wr_en[l] && (wr_addr == rd_addr)) begin
          rd_data[l*SRAM_LANE_W +: SRAM_LANE_W] <= wr_data[l*SRAM_LANE_W +: SRAM_LANE_W];
        end else begin
          rd_data[l*SRAM_LANE_W +: SRAM_LANE_W] <= mem_q[rd_addr][l*SRAM_LANE_W +: SRAM_LANE_W];
        end
      end
    end
  end

endmodule

// File: rtl/zbt_sram_responder.sv
// Pipelined (latency 2) ZBT SRAM memory model answering the board SRAM pin protocol.
module zbt_sram_responder
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH_BITS = 12,
  parameter int unsigned DATA_W     = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SRAM_ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0]      sram_data,
  input  logic [1:0]             sram_bw,
  input  logic                   sram_advload,
  input  logic                   sram_write_enable,
  input  logic                   sram_chip_enable,
  input  logic                   sram_oe,
  input  logic                   sram_clk_enable
);

  localparam int unsigned Last = SRAM_PIPE_LAT - 1;

  sram_cmd_t              pipe_q [SRAM_PIPE_LAT];
  sram_cmd_t              cmd_d;
  sram_op_e               last_op_q, last_op_d;
  logic [SRAM_ADDR_W-1:0] base_q, base_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   out_rd_q;
  logic                   clk_en;
  logic                   rd_en;
  logic [1:0]             wr_en;
  logic [DEPTH_BITS-1:0]  exec_addr;
  logic [SRAM_DATA_W-1:0] rd_data;
  logic                   unused_addr_hi;

  assign clk_en = ~sram_clk_enable;

  always_comb begin
    cmd_d.op   = OP_NOP;
    cmd_d.addr = sram_addr;
    cmd_d.bw   = sram_bw;
    last_op_d  = last_op_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    if (!sram_chip_enable) begin
      last_op_d = OP_NOP;
    end else if (!sram_advload) begin
      cmd_d.op  = sram_write_enable ? OP_RD : OP_WR;
      base_d    = sram_addr;
      cnt_d     = 2'd0;
      last_op_d = cmd_d.op;
    end else if (last_op_q != OP_NOP) begin
      // Advance after a NOP stays a NOP; otherwise continue the burst type.
      cmd_d.op   = last_op_q;
      cmd_d.addr = burst_addr(base_q, cnt_q);
      cnt_d      = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SRAM_PIPE_LAT; i++) begin
        pipe_q[i] <= '{op: OP_NOP, addr: '0, bw: 2'b11};
      end
      last_op_q <= OP_NOP;
      base_q    <= '0;
      cnt_q     <= 2'd0;
      out_rd_q  <= 1'b0;
    end else if (clk_en) begin
      pipe_q[0] <= cmd_d;
      for (int unsigned i = 1; i < SRAM_PIPE_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      last_op_q <= last_op_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      out_rd_q  <= (pipe_q[Last].op == OP_RD);
    end
  end

  assign exec_addr      = pipe_q[Last].addr[DEPTH_BITS-1:0];
  assign unused_addr_hi = ^pipe_q[Last].addr[SRAM_ADDR_W-1:DEPTH_BITS];
  assign rd_en          = clk_en && (pipe_q[Last].op == OP_RD);
  assign wr_en          = {2{clk_en && (pipe_q[Last].op == OP_WR)}} & ~pipe_q[Last].bw;

  zbt_sram_array #(
    .DEPTH_BITS(DEPTH_BITS)
  ) u_array (
    .clk    (clk),
    .rd_en  (rd_en),
    .rd_addr(exec_addr),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_addr(exec_addr),
    .wr_data(sram_data)
  );

  // Output enable is purely combinational on top of the registered read slot.
  assign sram_data = (out_rd_q && !sram_oe) ? rd_data : 'z;

endmodule

// File: tb/tb_zbt_sram_responder.sv
// Randomized and directed bench for zbt_sram_responder against a cycle-indexed memory model.
module tb_zbt_sram_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] sram_addr = '0;
  logic [1:0]  sram_bw = 2'b11;
  logic        sram_advload = 1'b0;
  logic        sram_write_enable = 1'b1;
  logic        sram_chip_enable = 1'b0;
  logic        sram_oe = 1'b0;
  logic        sram_clk_enable = 1'b0;
  wire  [17:0] sram_data;
  logic        tb_en = 1'b0;
  logic [17:0] tb_drv = '0;
  wire         bus_z;

  assign sram_data = tb_en ? tb_drv : 18'bz;
  assign bus_z     = (sram_data === 18'bz);

  always #5 clk = ~clk;

  zbt_sram_responder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sram_addr        (sram_addr),
    .sram_data        (sram_data),
    .sram_bw          (sram_bw),
    .sram_advload     (sram_advload),
    .sram_write_enable(sram_write_enable),
    .sram_chip_enable (sram_chip_enable),
    .sram_oe          (sram_oe),
    .sram_clk_enable  (sram_clk_enable)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Model: ops are scheduled by index of enabled clock edges; op issued at edge e acts at e+2.
  logic [17:0] mem [4096];
  int          s_kind [int];  // 1 = read, 2 = write
  int          s_addr [int];
  logic [1:0]  s_bw [int];
  logic [17:0] s_wd [int];
  int          e = 0;
  int          m_last = 0;
  int          m_prev = 0;
  int          m_base = 0;
  int          m_cnt = 0;
  logic        out_valid = 1'b0;
  logic [17:0] out_data = '0;

  task automatic chk_bus(input string name, input logic exp_drv, input logic [17:0] exp_val);
    logic ok;
    n_checks++;
    ok = exp_drv ? (!bus_z && (sram_data == exp_val)) : bus_z;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at %0t: bus z=%0b val=%h, required drive=%0b val=%h",
               name, $time, bus_z, sram_data, exp_drv, exp_val);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) chk_bus("reset_z", 1'b0, 18'h0);
    else if (out_valid && !sram_oe) chk_bus("model_rd", 1'b1, out_data);
    else if (!tb_en) chk_bus("model_idle", 1'b0, 18'h0);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    tb_en = 1'b0;
    sram_chip_enable = 1'b0;
    sram_clk_enable = 1'b0;
    sram_oe = 1'b0;
    s_kind.delete();
    s_addr.delete();
    s_bw.delete();
    s_wd.delete();
    out_valid = 1'b0;
    m_last = 0;
    m_prev = 0;
    e = 0;
    #1 chk_bus("reset_release", 1'b0, 18'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic tick(input logic ce, input logic adv, input logic we_n, input logic [19:0] a,
                      input logic [1:0] bw, input logic [17:0] wd, input logic cken,
                      input logic oe);
    int op;
    int ad;
    int idx;
    sram_chip_enable = ce;
    sram_advload = adv;
    sram_write_enable = we_n;
    sram_addr = a;
    sram_bw = bw;
    sram_clk_enable = cken;
    sram_oe = oe;
    if (s_kind.exists(e + 1) && s_kind[e+1] == 2) begin
      tb_en = 1'b1;
      tb_drv = s_wd[e+1];
    end else begin
      tb_en = 1'b0;
    end
    @(posedge clk);
    if (!cken) begin
      e++;
      op = 0;
      ad = 0;
      if (!ce) begin
        m_last = 0;
      end else if (!adv) begin
        op = we_n ? 1 : 2;
        ad = int'(a);
        m_base = ad;
        m_cnt = 0;
        m_last = op;
      end else if (m_last != 0) begin
        m_cnt = (m_cnt + 1) % 4;
        ad = (m_base & ~3) | ((m_base + m_cnt) & 3);
        op = m_last;
      end
      if (op != 0) begin
        s_kind[e+2] = op;
        s_addr[e+2] = ad % 4096;
        s_bw[e+2] = bw;
        s_wd[e+2] = wd;
      end
      m_prev = op;
      out_valid = 1'b0;
      if (s_kind.exists(e)) begin
        idx = s_addr[e];
        if (s_kind[e] == 2) begin
          if (!s_bw[e][0]) mem[idx][8:0] = s_wd[e][8:0];
          if (!s_bw[e][1]) mem[idx][17:9] = s_wd[e][17:9];
        end else begin
          out_valid = 1'b1;
          out_data = mem[idx];
        end
        s_kind.delete(e);
        s_addr.delete(e);
        s_bw.delete(e);
        s_wd.delete(e);
      end
    end
    #1;
  endtask

  task automatic nop();
    tick(1'b0, 1'b0, 1'b1, 20'h0, 2'b11, 18'h0, 1'b0, 1'b0);
  endtask
  task automatic wr(input logic [19:0] a, input logic [17:0] d, input logic [1:0] bw);
    tick(1'b1, 1'b0, 1'b0, a, bw, d, 1'b0, 1'b0);
  endtask
  task automatic rd(input logic [19:0] a);
    tick(1'b1, 1'b0, 1'b1, a, 2'b11, 18'h0, 1'b0, 1'b0);
  endtask
  task automatic adv(input logic [17:0] d);
    tick(1'b1, 1'b1, 1'b1, 20'h0, 2'b00, d, 1'b0, 1'b0);
  endtask
  task automatic susp();
    tick(1'b0, 1'b0, 1'b1, 20'h0, 2'b11, 18'h0, 1'b1, 1'b0);
  endtask

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, required completion before %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic        ce, av, we_n, ck, oe;
    logic [7:0]  hi;
    logic [5:0]  lo;
    logic [1:0]  bw;
    logic [17:0] wd;
    int          r;

    do_reset();

    // Fill the 64-word window used by all tests.
    for (int i = 0; i < 64; i++) wr(20'(i), 18'($urandom), 2'b00);
    repeat (3) nop();

    // Write then read two cycles later; bus only in the N+2..N+3 window.
    wr(20'h00010, 18'h2A5A5, 2'b00);
    nop();
    rd(20'h00010);
    nop();
    chk_bus("t1_pre", 1'b0, 18'h0);
    nop();
    chk_bus("t1_data", 1'b1, 18'h2A5A5);
    nop();
    chk_bus("t1_post", 1'b0, 18'h0);

    // Lower-lane-only write, plus an aliased read of the same word.
    wr(20'h00005, 18'h00000, 2'b00);
    nop();
    wr(20'h00005, 18'h3FFFF, 2'b10);
    nop();
    rd(20'h00005);
    nop();
    nop();
    chk_bus("t2_lane", 1'b1, 18'h001FF);
    rd(20'h50005);
    nop();
    nop();
    chk_bus("t2_alias", 1'b1, 18'h001FF);
    nop();

    // Burst write 0xC..0xF, then a wrapping burst read from 0xE.
    wr(20'h0000C, 18'h1000C, 2'b00);
    adv(18'h1000D);
    adv(18'h1000E);
    adv(18'h1000F);
    rd(20'h0000E);
    adv(18'h0);
    adv(18'h0);
    chk_bus("t3_e", 1'b1, 18'h1000E);
    adv(18'h0);
    chk_bus("t3_f", 1'b1, 18'h1000F);
    nop();
    chk_bus("t3_c", 1'b1, 18'h1000C);
    nop();
    chk_bus("t3_d", 1'b1, 18'h1000D);
    nop();
    chk_bus("t3_end", 1'b0, 18'h0);

    // Write immediately followed by a read of the same word.
    wr(20'h00020, 18'h11111, 2'b00);
    rd(20'h00020);
    nop();
    nop();
    chk_bus("t4_raw", 1'b1, 18'h11111);
    nop();
    nop();

    // Clock suspend delays the read; held output survives suspend; OE gates asynchronously.
    rd(20'h00010);
    repeat (3) begin
      susp();
      chk_bus("t5_susp_z", 1'b0, 18'h0);
    end
    nop();
    chk_bus("t5_late_z", 1'b0, 18'h0);
    nop();
    chk_bus("t5_late_data", 1'b1, 18'h2A5A5);
    repeat (2) begin
      susp();
      chk_bus("t5_hold", 1'b1, 18'h2A5A5);
    end
    sram_oe = 1'b1;
    #1 chk_bus("t5_oe_off", 1'b0, 18'h0);
    sram_oe = 1'b0;
    #1 chk_bus("t5_oe_on", 1'b1, 18'h2A5A5);
    nop();
    chk_bus("t5_end", 1'b0, 18'h0);
    nop();

    // Reset between a write command and its data edge.
    rd(20'h00020);
    wr(20'h00010, 18'h3C3C3, 2'b00);
    nop();
    chk_bus("t6_drive", 1'b1, 18'h11111);
    do_reset();
    rd(20'h00010);
    nop();
    nop();
    chk_bus("t6_kept", 1'b1, 18'h2A5A5);
    nop();

    // Randomized traffic; a write right after a read would collide on the bus.
    repeat (1500) begin
      ce   = ($urandom_range(0, 9) != 0);
      av   = ($urandom_range(0, 9) < 4);
      we_n = 1'($urandom_range(0, 1));
      hi   = 8'($urandom);
      lo   = 6'($urandom);
      bw   = 2'($urandom);
      wd   = 18'($urandom);
      ck   = ($urandom_range(0, 9) == 0);
      oe   = ($urandom_range(0, 6) == 0);
      r    = !ce ? 0 : (!av ? (we_n ? 1 : 2) : m_last);
      if (!ck && r == 2 && m_prev == 1) ce = 1'b0;
      tick(ce, av, we_n, {hi, 6'b0, lo}, bw, wd, ck, oe);
    end
    repeat (4) nop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
